// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared FSM/owner types and word widths for the RAM access sequencer
package ram_seq_pkg;
    localparam int HALF_W = 16;
    localparam int WORD_W = 2 * HALF_W;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
endpackage

// File: rtl/half_word_packer.sv
// half_word_packer: captures the low and high RAM halves and holds the assembled read word per owner
module half_word_packer
    import ram_seq_pkg::*;
#(
    parameter int W = HALF_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           i_lo_stb,
    input  logic           i_hi_stb,
    input  owner_t         i_owner,
    input  logic [W-1:0]   i_half,
    output logic [2*W-1:0] o_if_word,
    output logic [2*W-1:0] o_mem_word
);
    logic [W-1:0]   r_lo;
    logic [2*W-1:0] r_if_word;
    logic [2*W-1:0] r_mem_word;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lo       <= '0;
            r_if_word  <= '0;
            r_mem_word <= '0;
        end else begin
            if (i_lo_stb) r_lo <= i_half;
            if (i_hi_stb && i_owner == OWN_IF) r_if_word <= {i_half, r_lo};
            if (i_hi_stb && i_owner == OWN_MEM) r_mem_word <= {i_half, r_lo};
        end
    end
    assign o_if_word  = r_if_word;
    assign o_mem_word = r_mem_word;
endmodule

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: shares one 16-bit RAM between IF and MEM, two half-word cycles per 32-bit access.
// RAM_SEQ_RR_EN selects round-robin tie-breaking; otherwise MEM has fixed priority.
module ram_access_sequencer #(
    parameter int ADDR_W = 18,
    parameter int HALF_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [2*HALF_W-1:0] if_rdata,
    output logic                if_ack,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [2*HALF_W-1:0] mem_wdata,
    output logic [2*HALF_W-1:0] mem_rdata,
    output logic                mem_ack,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wre,
    output logic [HALF_W-1:0]   ram_wdata,
    input  logic [HALF_W-1:0]   ram_rdata
);
    import ram_seq_pkg::*;
    state_t              r_state, w_state_d;
    owner_t              r_own, w_own;
    logic                r_we;
    logic [HALF_W-1:0]   r_wd_hi;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_d;
    logic                r_ram_wre, w_ram_wre_d;
    logic [HALF_W-1:0]   r_ram_wdata, w_ram_wdata_d;
    logic                r_if_ack, r_mem_ack;
    logic                w_if_ok, w_mem_ok, w_grant, w_lo_stb, w_hi_stb;
    // Ack is registered out of DONE, so the IDLE cycle carrying it must not re-grant that same requester.
    assign w_if_ok  = if_req && !r_if_ack;
    assign w_mem_ok = mem_req && !r_mem_ack;
    assign w_grant  = (r_state == IDLE) && (w_if_ok || w_mem_ok);
`ifdef RAM_SEQ_RR_EN
    owner_t r_last;
    assign w_own = (w_if_ok && w_mem_ok) ? ((r_last == OWN_MEM) ? OWN_IF : OWN_MEM)
                                         : (w_mem_ok ? OWN_MEM : OWN_IF);
    always_ff @(posedge clock) begin
        if (reset) r_last <= OWN_IF;
        else if (w_grant) r_last <= w_own;
    end
`else
    assign w_own = w_mem_ok ? OWN_MEM : OWN_IF;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_own       <= OWN_IF;
            r_we        <= 1'b0;
            r_wd_hi     <= '0;
            r_ram_addr  <= '0;
            r_ram_wre   <= 1'b0;
            r_ram_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ram_addr  <= w_ram_addr_d;
            r_ram_wre   <= w_ram_wre_d;
            r_ram_wdata <= w_ram_wdata_d;
            r_if_ack    <= (r_state == DONE) && (r_own == OWN_IF);
            r_mem_ack   <= (r_state == DONE) && (r_own == OWN_MEM);
            if (w_grant) begin
                r_own   <= w_own;
                r_we    <= (w_own == OWN_MEM) && mem_we;
                r_wd_hi <= (w_own == OWN_MEM) ? mem_wdata[2*HALF_W-1:HALF_W] : '0;
            end
        end
    end
    always_comb begin
        w_state_d = (r_state == IDLE) ? (w_grant ? LO : IDLE) :
                    (r_state == LO)   ? HI :
                    (r_state == HI)   ? DONE : IDLE;
    end
    always_comb begin
        w_lo_stb      = (r_state == HI);
        w_hi_stb      = (r_state == DONE) && !r_we;
        w_ram_addr_d  = r_ram_addr;
        w_ram_wre_d   = r_ram_wre;
        w_ram_wdata_d = r_ram_wdata;
        if (w_grant) begin
            w_ram_addr_d  = (w_own == OWN_MEM) ? mem_addr : if_addr;
            w_ram_wre_d   = (w_own == OWN_MEM) && mem_we;
            w_ram_wdata_d = (w_own == OWN_MEM) ? mem_wdata[HALF_W-1:0] : '0;
        end else if (r_state == LO) begin
            w_ram_addr_d  = r_ram_addr + ADDR_W'(1);
            w_ram_wdata_d = r_wd_hi;
        end else if (r_state == HI) begin
            w_ram_wre_d   = 1'b0;
        end
    end
    half_word_packer #(.W(HALF_W)) u_packer (
        .clock      (clock),
        .reset      (reset),
        .i_lo_stb   (w_lo_stb),
        .i_hi_stb   (w_hi_stb),
        .i_owner    (r_own),
        .i_half     (ram_rdata),
        .o_if_word  (if_rdata),
        .o_mem_word (mem_rdata)
    );
    assign ram_addr  = r_ram_addr;
    assign ram_wre   = r_ram_wre;
    assign ram_wdata = r_ram_wdata;
    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: RAM emulation, transaction-level model with per-cycle compare, directed literal checks
module tb_ram_access_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [17:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [17:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [17:0] ram_addr;
    logic        ram_wre;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] e_ram [0:262143];
    logic [15:0] m_ram [0:262143];
    ram_access_sequencer #(.ADDR_W(18), .HALF_W(16)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_addr(ram_addr), .ram_wre(ram_wre), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );
    always #5 clock = ~clock;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    task automatic poke(input logic [17:0] a, input logic [15:0] d);
        e_ram[a] = d;
        m_ram[a] = d;
    endtask
    // Synchronous RAM: address registered on the edge, read data valid the following cycle.
    always @(posedge clock) begin
        if (ram_wre) e_ram[ram_addr] <= ram_wdata;
        ram_rdata <= e_ram[ram_addr];
    end
    // Transaction model: k counts cycles since the grant edge (1..3 = access, 4 = ack cycle).
    int          k = 0;
    logic        m_on = 1'b0, m_own = 1'b0, m_last = 1'b0, m_we = 1'b0;
    logic        ok_if, ok_mem;
    logic [17:0] m_a = '0, m_a1 = '0;
    logic [31:0] m_wd = '0, m_exp = '0;
    always @(posedge clock) begin
        if (reset) begin
            k = 0;
            m_on = 1'b1;
            m_last = 1'b0;
        end else if (k == 0 || k == 4) begin
            ok_if  = if_req && !(k == 4 && !m_own);
            ok_mem = mem_req && !(k == 4 && m_own);
            if (ok_if || ok_mem) begin
`ifdef RAM_SEQ_RR_EN
                m_own = (ok_if && ok_mem) ? !m_last : ok_mem;
`else
                m_own = ok_mem;
`endif
                m_last = m_own;
                m_a  = m_own ? mem_addr : if_addr;
                m_a1 = m_a + 18'd1;
                m_we = m_own && mem_we;
                m_wd = mem_wdata;
                if (m_we) begin
                    m_ram[m_a]  = m_wd[15:0];
                    m_ram[m_a1] = m_wd[31:16];
                end else m_exp = {m_ram[m_a1], m_ram[m_a]};
                k = 1;
            end else k = 0;
        end else k = k + 1;
    end
    always @(negedge clock) begin
        if (m_on) begin
            chk("ram_wre", {31'd0, ram_wre}, {31'd0, m_we && (k == 1 || k == 2)});
            chk("if_ack", {31'd0, if_ack}, {31'd0, k == 4 && !m_own});
            chk("mem_ack", {31'd0, mem_ack}, {31'd0, k == 4 && m_own});
            if (k == 1) chk("ram_addr_lo", {14'd0, ram_addr}, {14'd0, m_a});
            if (k == 2) chk("ram_addr_hi", {14'd0, ram_addr}, {14'd0, m_a1});
            if (m_we && k == 1) chk("ram_wdata_lo", {16'd0, ram_wdata}, {16'd0, m_wd[15:0]});
            if (m_we && k == 2) chk("ram_wdata_hi", {16'd0, ram_wdata}, {16'd0, m_wd[31:16]});
            if (k == 4 && !m_we) chk(m_own ? "mem_rdata" : "if_rdata", m_own ? mem_rdata : if_rdata, m_exp);
        end
    end
    logic        rec_wre [0:15];
    logic [17:0] rec_addr [0:15];
    logic [15:0] rec_wd [0:15];
    task automatic access(input logic own_mem, input logic we, input logic [17:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
        lat = -1;
        rd = '0;
        @(posedge clock); #2;
        if (own_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        for (int n = 0; n < 12 && lat < 0; n++) begin
            @(negedge clock);
            rec_wre[n] = ram_wre; rec_addr[n] = ram_addr; rec_wd[n] = ram_wdata;
            if (own_mem ? mem_ack : if_ack) begin
                lat = n;
                rd = own_mem ? mem_rdata : if_rdata;
            end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
    endtask
    task automatic contend(input logic mem_first);
        int ti = -1, tm = -1;
        @(posedge clock); #2;
        if_req = 1'b1; if_addr = 18'h00010;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00020;
        for (int n = 0; n < 20 && (ti < 0 || tm < 0); n++) begin
            @(negedge clock);
            if (if_ack) begin ti = n; if_req = 1'b0; chk("tie_if_data", if_rdata, 32'hDEADBEEF); end
            if (mem_ack) begin tm = n; mem_req = 1'b0; chk("tie_mem_data", mem_rdata, 32'h33334444); end
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        chk("tie_first_lat", mem_first ? tm : ti, 32'd4);
        chk("tie_second_lat", mem_first ? ti : tm, 32'd8);
    endtask
    initial begin
        int          lat, cnt;
        logic [31:0] rd;
        for (int i = 0; i < 262144; i++) begin
            e_ram[i] = 16'(i) ^ 16'hA5A5;
            m_ram[i] = 16'(i) ^ 16'hA5A5;
        end
        poke(18'h00010, 16'hBEEF); poke(18'h00011, 16'hDEAD);
        poke(18'h00020, 16'h4444); poke(18'h00021, 16'h3333);
        poke(18'h3FFFF, 16'h1111); poke(18'h00000, 16'h2222);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ram_addr", {14'd0, ram_addr}, 32'd0);
        chk("rst_ram_wre", {31'd0, ram_wre}, 32'd0);
        chk("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_acks", {30'd0, if_ack, mem_ack}, 32'd0);
        @(posedge clock); #2 reset = 1'b0;
        access(1'b0, 1'b0, 18'h00010, 32'd0, lat, rd);
        chk("if_read_lat", lat, 32'd4);
        chk("if_read_data", rd, 32'hDEADBEEF);
        access(1'b1, 1'b1, 18'h00100, 32'h12345678, lat, rd);
        chk("wr_lat", lat, 32'd4);
        chk("wr_lo", {rec_wre[1], 5'd0, rec_addr[1], 8'd0}, {1'b1, 5'd0, 18'h00100, 8'd0});
        chk("wr_lo_data", {16'd0, rec_wd[1]}, 32'h00005678);
        chk("wr_hi", {rec_wre[2], 5'd0, rec_addr[2], 8'd0}, {1'b1, 5'd0, 18'h00101, 8'd0});
        chk("wr_hi_data", {16'd0, rec_wd[2]}, 32'h00001234);
        chk("wr_done_wre", {31'd0, rec_wre[3]}, 32'd0);
        access(1'b0, 1'b0, 18'h00100, 32'd0, lat, rd);
        chk("wr_readback", rd, 32'h12345678);
        contend(1'b1);
        access(1'b1, 1'b1, 18'h00300, 32'hCAFEF00D, lat, rd);
`ifdef RAM_SEQ_RR_EN
        contend(1'b0);
`else
        contend(1'b1);
`endif
        access(1'b1, 1'b0, 18'h3FFFF, 32'd0, lat, rd);
        chk("wrap_hi_addr", {14'd0, rec_addr[2]}, 32'd0);
        chk("wrap_data", rd, 32'h22221111);
        @(posedge clock); #2;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00200; mem_wdata = 32'hAAAA5555;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("hi_wre_before_rst", {31'd0, ram_wre}, 32'd1);
        chk("hi_addr_before_rst", {14'd0, ram_addr}, 32'h00000201);
        reset = 1'b1;
        mem_req = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_mid_wre", {31'd0, ram_wre}, 32'd0);
        @(posedge clock); #2 reset = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            cnt += int'(if_ack) + int'(mem_ack);
        end
        chk("rst_mid_no_ack", cnt, 32'd0);
        access(1'b0, 1'b0, 18'h00010, 32'd0, lat, rd);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_data", rd, 32'hDEADBEEF);
        cnt = 0;
        repeat (20) begin
            @(negedge clock);
            cnt += int'(if_ack) + int'(mem_ack) + int'(ram_wre);
        end
        chk("idle_quiet", cnt, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
